// File: rtl/ula_muldiv.sv
// Iterative multiply/divide unit driving the HI/LO register pair.
// One shift-add or restoring shift-subtract step per clock.
module ula_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic             r_div;
  logic             r_negq;
  logic             r_negr;
  logic             r_dz;
  logic             r_done;
  logic             r_dzo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_signed;
  logic             w_s1;
  logic             w_s2;
  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH:0]   w_sub;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prodc;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;

  assign w_signed = ~op[0];
  assign w_s1     = w_signed & In1[WIDTH-1];
  assign w_s2     = w_signed & In2[WIDTH-1];
  assign w_abs1   = w_s1 ? -In1 : In1;
  assign w_abs2   = w_s2 ? -In2 : In2;

  // r_a is the running high half (product) or partial remainder (divide)
  assign w_add = {1'b0, r_a} + (r_b[0] ? {1'b0, r_m} : '0);
  assign w_sh  = {r_a, r_b[WIDTH-1]};
  assign w_sub = w_sh - {1'b0, r_m};

  assign w_prod  = {r_a, r_b};
  assign w_prodc = r_negq ? -w_prod : w_prod;
  assign w_q     = r_negq ? -r_b : r_b;
  assign w_r     = r_negr ? -r_a : r_a;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_m     <= '0;
      r_div   <= 1'b0;
      r_negq  <= 1'b0;
      r_negr  <= 1'b0;
      r_dz    <= 1'b0;
      r_done  <= 1'b0;
      r_dzo   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      r_dzo  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !op[2]) begin
            r_div  <= op[1];
            r_cnt  <= CW'(WIDTH - 1);
            r_negq <= w_s1 ^ w_s2;
            r_negr <= w_s1;
            r_a    <= '0;
            r_dz   <= 1'b0;
            r_state <= S_RUN;
            if (op[1]) begin
              r_m <= w_abs2;
              r_b <= w_abs1;
              if (In2 == '0) begin
                r_dz    <= 1'b1;
                r_a     <= In1;
                r_state <= S_FIX;
              end
            end else begin
              r_m <= w_abs1;
              r_b <= w_abs2;
            end
          end else if (start && op == OP_MTHI) begin
            r_hi <= In1;
          end else if (start && op == OP_MTLO) begin
            r_lo <= In1;
          end
        end
        S_RUN: begin
          if (r_div) begin
            if (!w_sub[WIDTH]) begin
              r_a <= w_sub[WIDTH-1:0];
              r_b <= {r_b[WIDTH-2:0], 1'b1};
            end else begin
              r_a <= w_sh[WIDTH-1:0];
              r_b <= {r_b[WIDTH-2:0], 1'b0};
            end
          end else begin
            r_a <= w_add[WIDTH:1];
            r_b <= {w_add[0], r_b[WIDTH-1:1]};
          end
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_dz) begin
            r_hi <= r_a;
            r_lo <= '1;
          end else if (r_div) begin
            r_hi <= w_r;
            r_lo <= w_q;
          end else begin
            r_hi <= w_prodc[2*WIDTH-1:WIDTH];
            r_lo <= w_prodc[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_dzo   <= r_dz;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dzo;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_ula_muldiv.sv
// Scoreboard bench for ula_muldiv: expected HI/LO pushed at issue,
// popped and compared by a monitor whenever done pulses.
module tb_ula_muldiv;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] In1;
  logic [31:0] In2;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  ula_muldiv #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .In1        (In1),
    .In2        (In2),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l,
                      input logic d);
    exp_t e;
    e.hi = h;
    e.lo = l;
    e.dz = d;
    sb.push_back(e);
  endtask

  task automatic issue(input bit sync, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    if (!sync) @(negedge clk);
    start = 1'b1;
    op    = o;
    In1   = a;
    In2   = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < max && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL done_timeout: no done within %0d cycles", max);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && done) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_done: hi=0x%08h lo=0x%08h", hi, lo);
        end else begin
          e = sb.pop_front();
          if (hi !== e.hi || lo !== e.lo || div_by_zero !== e.dz) begin
            n_err++;
            $display("FAIL result: got hi=0x%08h lo=0x%08h dz=%0b expected hi=0x%08h lo=0x%08h dz=%0b",
                     hi, lo, div_by_zero, e.hi, e.lo, e.dz);
          end
        end
      end
    end
  endtask

  initial begin
    int lat;
    int bc;
    bit chg;
    bit extra;

    reset = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    In1   = '0;
    In2   = '0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    reset = 1'b0;

    issue(0, 3'b101, 32'hAB, 0);
    chk("mtlo_lo", lo, 32'hAB);
    @(negedge clk);
    chk("mtlo_done", 32'(done), 0);
    chk("mtlo_busy", 32'(busy), 0);
    issue(0, 3'b100, 32'h55, 0);
    chk("mthi_hi", hi, 32'h55);

    push(32'hFFFF_FFFE, 32'h0000_0001, 0);
    issue(0, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    lat = 0;
    bc  = 0;
    chg = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        lat = k;
        break;
      end
      if (hi !== 32'h55 || lo !== 32'hAB) chg = 1'b1;
      @(posedge clk);
    end
    chk("multu_latency", lat, 34);
    chk("multu_busy_cycles", bc, 33);
    chk("multu_no_partial", 32'(chg), 0);

    push(32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    issue(0, 3'b000, 32'hFFFF_FFFD, 32'd5);
    wait_done(40);
    push(32'h4000_0000, 32'h0, 0);
    issue(0, 3'b000, 32'h8000_0000, 32'h8000_0000);
    wait_done(40);
    push(32'h0000_0001, 32'h2345_6780, 0);
    issue(0, 3'b001, 32'h1234_5678, 32'h10);
    wait_done(40);
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    issue(0, 3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_done(40);
    push(32'd1, 32'd3, 0);
    issue(0, 3'b011, 32'd7, 32'd2);
    wait_done(40);
    push(32'd1, 32'hFFFF_FFFD, 0);
    issue(0, 3'b010, 32'd7, 32'hFFFF_FFFE);
    wait_done(40);
    push(32'h0, 32'h8000_0000, 0);
    issue(0, 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(40);

    push(32'h1234, 32'hFFFF_FFFF, 1);
    issue(0, 3'b011, 32'h1234, 32'h0);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      @(posedge clk);
    end
    chk("div0_latency", lat, 2);
    push(32'h0, 32'd2, 0);
    issue(0, 3'b011, 32'd8, 32'd4);
    wait_done(40);

    push(32'h0, 32'd6, 0);
    issue(0, 3'b000, 32'd2, 32'd3);
    repeat (5) @(posedge clk);
    issue(0, 3'b010, 32'd100, 32'd5);
    wait_done(40);
    @(negedge clk);
    chk("busy_start_ignored", 32'(busy), 0);

    issue(0, 3'b110, 32'd9, 32'd9);
    @(negedge clk);
    chk("undef_op_busy", 32'(busy), 0);
    chk("undef_op_lo", lo, 32'd6);

    push(32'h0, 32'd12, 0);
    issue(0, 3'b001, 32'd3, 32'd4);
    wait_done(40);
    push(32'd2, 32'd14, 0);
    issue(1, 3'b011, 32'd100, 32'd7);
    wait_done(40);

    issue(0, 3'b000, 32'd7, 32'd9);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_done", 32'(done), 0);
    chk("async_rst_hi", hi, 0);
    chk("async_rst_lo", lo, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    extra = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) extra = 1'b1;
    end
    chk("no_done_after_reset", 32'(extra), 0);
    push(32'h0, 32'd42, 0);
    issue(0, 3'b001, 32'd6, 32'd7);
    wait_done(40);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
